// File: rtl/jml_i2c_sync_if.sv
// rtl/jml_i2c_sync_if.sv - register bridge bus between the I2C target and a register file
interface jml_i2c_sync_if #(
    parameter int ADDR_W = 6
);
    logic [ADDR_W-1:0] addr;
    logic              read;
    logic              write;
    logic [7:0]        write_data;
    logic [7:0]        read_data;

    // The I2C target owns the request side of the bridge
    modport master (
        output addr,
        output read,
        output write,
        output write_data,
        input  read_data
    );

    // The register file answers reads
    modport slave (
        input  addr,
        input  read,
        input  write,
        input  write_data,
        output read_data
    );
endinterface

// File: rtl/jml_i2c_sync.sv
// rtl/jml_i2c_sync.sv - oversampled I2C target with register read/write bridge
module jml_i2c_sync #(
    parameter logic [6:0] MYI2C_ADDR = 7'h10,
    parameter int         ADDR_W     = 6,
    parameter int         FILT       = 3
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           scl,
    input  logic           sda,
    output logic           sda_drv_lo,
    jml_i2c_sync_if.master bus
);

    localparam logic [3:0] IDLE      = 4'd0;
    localparam logic [3:0] DEV_ADDR  = 4'd1;
    localparam logic [3:0] DEV_ACK   = 4'd2;
    localparam logic [3:0] REG_ADDR  = 4'd3;
    localparam logic [3:0] REG_ACK   = 4'd4;
    localparam logic [3:0] WDATA     = 4'd5;
    localparam logic [3:0] WDATA_ACK = 4'd6;
    localparam logic [3:0] RDATA     = 4'd7;
    localparam logic [3:0] RDATA_ACK = 4'd8;

    // Filter counter terminal value: output flips on the FILT-th differing sample
    localparam logic [2:0] FILT_LAST = 3'(FILT - 1);

    logic [1:0]        scl_sync;
    logic [1:0]        sda_sync;
    logic [2:0]        scl_cnt;
    logic [2:0]        sda_cnt;
    logic              scl_f;
    logic              sda_f;
    logic              scl_d;
    logic              sda_d;

    logic              scl_rise;
    logic              scl_fall;
    logic              start_evt;
    logic              stop_evt;

    logic [3:0]        state;
    logic [3:0]        bit_cnt;
    logic [7:0]        shift;
    logic [7:0]        byte_in;
    logic              byte_done;
    logic              rw;
    logic [1:0]        rd_ph;
    logic              drv;
    logic [ADDR_W-1:0] addr_q;
    logic              read_q;
    logic              write_q;
    logic [7:0]        wdata_q;

    // SCL: two-flop synchronizer followed by a consecutive-sample glitch filter
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            scl_sync <= 2'b11;
            scl_cnt  <= 3'd0;
            scl_f    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl};
            if (scl_sync[1] == scl_f) begin
                scl_cnt <= 3'd0;
            end else if (scl_cnt == FILT_LAST) begin
                scl_f   <= scl_sync[1];
                scl_cnt <= 3'd0;
            end else begin
                scl_cnt <= scl_cnt + 3'd1;
            end
        end
    end

    // SDA: same synchronizer and filter so both pins see identical latency
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sda_sync <= 2'b11;
            sda_cnt  <= 3'd0;
            sda_f    <= 1'b1;
        end else begin
            sda_sync <= {sda_sync[0], sda};
            if (sda_sync[1] == sda_f) begin
                sda_cnt <= 3'd0;
            end else if (sda_cnt == FILT_LAST) begin
                sda_f   <= sda_sync[1];
                sda_cnt <= 3'd0;
            end else begin
                sda_cnt <= sda_cnt + 3'd1;
            end
        end
    end

    // Previous filtered values for single-clk edge and start/stop events
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            scl_d <= 1'b1;
            sda_d <= 1'b1;
        end else begin
            scl_d <= scl_f;
            sda_d <= sda_f;
        end
    end

    assign scl_rise  = scl_f & ~scl_d;
    assign scl_fall  = ~scl_f & scl_d;
    assign start_evt = sda_d & ~sda_f & scl_f;
    assign stop_evt  = ~sda_d & sda_f & scl_f;

    assign byte_in   = {shift[6:0], sda_f};
    assign byte_done = scl_rise && (bit_cnt == 4'd7);

    // Protocol FSM, bridge strobes and open-drain SDA control
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            bit_cnt <= 4'd0;
            shift   <= 8'h00;
            rw      <= 1'b0;
            rd_ph   <= 2'd0;
            drv     <= 1'b0;
            addr_q  <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            wdata_q <= 8'h00;
        end else begin
            read_q  <= 1'b0;
            write_q <= 1'b0;
            // Address auto-increments the clk after each write strobe
            if (write_q) begin
                addr_q <= addr_q + 1'b1;
            end

            if (start_evt) begin
                state   <= DEV_ADDR;
                bit_cnt <= 4'd0;
                drv     <= 1'b0;
                rd_ph   <= 2'd0;
            end else if (stop_evt) begin
                state   <= IDLE;
                bit_cnt <= 4'd0;
                drv     <= 1'b0;
                rd_ph   <= 2'd0;
            end else begin
                // Read fetch: strobe, then capture read_data, then present bit 7
                case (rd_ph)
                    2'd1: rd_ph <= 2'd2;
                    2'd2: begin
                        shift <= bus.read_data;
                        rd_ph <= 2'd3;
                    end
                    2'd3: begin
                        drv   <= ~shift[7];
                        rd_ph <= 2'd0;
                    end
                    default: ;
                endcase

                case (state)
                    DEV_ADDR: begin
                        if (scl_rise) begin
                            shift   <= byte_in;
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                        if (byte_done) begin
                            bit_cnt <= 4'd0;
                            rw      <= byte_in[0];
                            state   <= (byte_in[7:1] == MYI2C_ADDR) ? DEV_ACK : IDLE;
                        end
                    end
                    REG_ADDR: begin
                        if (scl_rise) begin
                            shift   <= byte_in;
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                        if (byte_done) begin
                            bit_cnt <= 4'd0;
                            addr_q  <= byte_in[ADDR_W-1:0];
                            state   <= REG_ACK;
                        end
                    end
                    WDATA: begin
                        if (scl_rise) begin
                            shift   <= byte_in;
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                        if (byte_done) begin
                            bit_cnt <= 4'd0;
                            wdata_q <= byte_in;
                            write_q <= 1'b1;
                            state   <= WDATA_ACK;
                        end
                    end
                    DEV_ACK, REG_ACK, WDATA_ACK: begin
                        // bit_cnt 0: falling edge after bit 8 starts the ACK;
                        // bit_cnt 1: the next falling edge ends it
                        if (scl_fall) begin
                            if (bit_cnt == 4'd0) begin
                                drv     <= 1'b1;
                                bit_cnt <= 4'd1;
                            end else begin
                                drv     <= 1'b0;
                                bit_cnt <= 4'd0;
                                if (state == DEV_ACK && rw) begin
                                    state  <= RDATA;
                                    read_q <= 1'b1;
                                    rd_ph  <= 2'd1;
                                end else if (state == DEV_ACK) begin
                                    state <= REG_ADDR;
                                end else begin
                                    state <= WDATA;
                                end
                            end
                        end
                    end
                    RDATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt != 4'd0) begin
                            if (bit_cnt == 4'd8) begin
                                drv     <= 1'b0;
                                bit_cnt <= 4'd0;
                                state   <= RDATA_ACK;
                            end else begin
                                shift <= {shift[6:0], 1'b0};
                                drv   <= ~shift[6];
                            end
                        end
                    end
                    RDATA_ACK: begin
                        // Master ACK advances the address; NACK parks in IDLE undriven
                        if (scl_rise) begin
                            if (!sda_f) begin
                                addr_q <= addr_q + 1'b1;
                            end else begin
                                state <= IDLE;
                            end
                        end else if (scl_fall) begin
                            state   <= RDATA;
                            read_q  <= 1'b1;
                            rd_ph   <= 2'd1;
                            bit_cnt <= 4'd0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign sda_drv_lo     = drv;
    assign bus.addr       = addr_q;
    assign bus.read       = read_q;
    assign bus.write      = write_q;
    assign bus.write_data = wdata_q;

endmodule

// File: tb/tb_jml_i2c_sync.sv
// tb/tb_jml_i2c_sync.sv - directed bench for jml_i2c_sync
module tb_jml_i2c_sync;

    localparam int Q    = 8;
    localparam int FILT = 3;

    logic clk = 1'b0;
    logic reset_n;
    logic scl;
    logic msda;
    logic sda_line;
    logic sda_drv_lo;
    logic [7:0] rdata_q = 8'h00;

    int checks = 0;
    int errors = 0;

    int wr_cnt = 0;
    int rd_cnt = 0;
    int both_cnt = 0;
    int drv_cnt = 0;
    logic [7:0] wr_addr_log [0:15];
    logic [7:0] wr_data_log [0:15];

    jml_i2c_sync_if #(.ADDR_W(6)) bus ();

    jml_i2c_sync #(
        .MYI2C_ADDR (7'h10),
        .ADDR_W     (6),
        .FILT       (FILT)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .scl        (scl),
        .sda        (sda_line),
        .sda_drv_lo (sda_drv_lo),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    assign sda_line = msda & ~sda_drv_lo;

    // Register file model: answers addr + 0x40 the clk after a read strobe
    always @(posedge clk) begin
        if (bus.read) rdata_q <= {2'b00, bus.addr} + 8'h40;
    end
    assign bus.read_data = rdata_q;

    // Strobe monitor
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.write) begin
                if (wr_cnt < 16) begin
                    wr_addr_log[wr_cnt] = {2'b00, bus.addr};
                    wr_data_log[wr_cnt] = bus.write_data;
                end
                wr_cnt = wr_cnt + 1;
            end
            if (bus.read) rd_cnt = rd_cnt + 1;
            if (bus.read && bus.write) both_cnt = both_cnt + 1;
            if (sda_drv_lo) drv_cnt = drv_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        msda = 1'b1; tick(Q);
        scl  = 1'b1; tick(Q);
        msda = 1'b0; tick(Q);
        scl  = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        msda = 1'b0; tick(Q);
        scl  = 1'b1; tick(Q);
        msda = 1'b1; tick(Q);
    endtask

    task automatic i2c_bit(input logic b, output logic r);
        msda = b; tick(Q);
        scl  = 1'b1; tick(Q);
        r    = sda_line; tick(Q);
        scl  = 1'b0; tick(Q);
    endtask

    // Same bit, but SDA flips for FILT-1 clks while SCL is high
    task automatic glitch_bit(input logic b, output logic r);
        msda = b; tick(Q);
        scl  = 1'b1; tick(3);
        msda = ~b; tick(FILT - 1);
        msda = b; tick(Q - 3 - (FILT - 1));
        r    = sda_line; tick(Q);
        scl  = 1'b0; tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) i2c_bit(d[i], r);
        i2c_bit(1'b1, r);
        ack = ~r;
    endtask

    task automatic glitch_byte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) glitch_bit(d[i], r);
        i2c_bit(1'b1, r);
        ack = ~r;
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            i2c_bit(1'b1, r);
            d[i] = r;
        end
        i2c_bit(~mack, r);
    endtask

    initial begin
        logic       ack;
        logic       r;
        logic [7:0] rb;
        int         wb;
        int         rbase;
        int         dbase;
        logic [7:0] regb;

        reset_n = 1'b0;
        scl     = 1'b1;
        msda    = 1'b1;
        tick(5);
        check("rst_drv", {31'd0, sda_drv_lo}, 32'd0);
        check("rst_addr", {26'd0, bus.addr}, 32'd0);
        check("rst_read", {31'd0, bus.read}, 32'd0);
        check("rst_write", {31'd0, bus.write}, 32'd0);
        check("rst_wdata", {24'd0, bus.write_data}, 32'd0);
        check("rst_state", {28'd0, dut.state}, 32'd0);
        reset_n = 1'b1;
        tick(10);

        // Two-byte write starting at register 5
        wb = wr_cnt;
        i2c_start();
        write_byte(8'h20, ack); check("w_dev_ack", {31'd0, ack}, 32'd1);
        write_byte(8'h05, ack); check("w_reg_ack", {31'd0, ack}, 32'd1);
        write_byte(8'hA5, ack); check("w_d0_ack", {31'd0, ack}, 32'd1);
        write_byte(8'h3C, ack); check("w_d1_ack", {31'd0, ack}, 32'd1);
        i2c_stop();
        tick(20);
        check("w_cnt", wr_cnt - wb, 32'd2);
        check("w_addr0", {24'd0, wr_addr_log[wb]}, 32'h05);
        check("w_data0", {24'd0, wr_data_log[wb]}, 32'hA5);
        check("w_addr1", {24'd0, wr_addr_log[wb + 1]}, 32'h06);
        check("w_data1", {24'd0, wr_data_log[wb + 1]}, 32'h3C);
        check("w_final_addr", {26'd0, bus.addr}, 32'h07);
        check("w_wdata_hold", {24'd0, bus.write_data}, 32'h3C);
        check("w_state_idle", {28'd0, dut.state}, 32'd0);

        // Set address 3F, repeated start, read two bytes across the wrap
        wb = wr_cnt;
        rbase = rd_cnt;
        i2c_start();
        write_byte(8'h20, ack); check("r_dev_ack", {31'd0, ack}, 32'd1);
        write_byte(8'h3F, ack); check("r_reg_ack", {31'd0, ack}, 32'd1);
        i2c_start();
        write_byte(8'h21, ack); check("r_rdev_ack", {31'd0, ack}, 32'd1);
        read_byte(1'b1, rb); check("r_byte0", {24'd0, rb}, 32'h7F);
        read_byte(1'b0, rb); check("r_byte1", {24'd0, rb}, 32'h40);
        i2c_stop();
        tick(20);
        check("r_pulses", rd_cnt - rbase, 32'd2);
        check("r_final_addr", {26'd0, bus.addr}, 32'h00);
        check("r_no_write", wr_cnt - wb, 32'd0);

        // Wrong device address: never acknowledged, bridge untouched
        wb = wr_cnt;
        rbase = rd_cnt;
        dbase = drv_cnt;
        i2c_start();
        write_byte(8'h22, ack); check("n_dev_nack", {31'd0, ack}, 32'd0);
        write_byte(8'h55, ack); check("n_data_nack", {31'd0, ack}, 32'd0);
        i2c_stop();
        tick(20);
        check("n_no_drive", drv_cnt - dbase, 32'd0);
        check("n_no_write", wr_cnt - wb, 32'd0);
        check("n_no_read", rd_cnt - rbase, 32'd0);
        check("n_addr", {26'd0, bus.addr}, 32'h00);

        // Short SDA glitches during every data bit are filtered out
        wb = wr_cnt;
        i2c_start();
        write_byte(8'h20, ack);
        write_byte(8'h10, ack);
        glitch_byte(8'h5A, ack); check("g_ack", {31'd0, ack}, 32'd1);
        i2c_stop();
        tick(20);
        check("g_cnt", wr_cnt - wb, 32'd1);
        check("g_addr", {24'd0, wr_addr_log[wb]}, 32'h10);
        check("g_data", {24'd0, wr_data_log[wb]}, 32'h5A);
        check("g_final_addr", {26'd0, bus.addr}, 32'h11);

        // Reset pulse while the register-address ACK is being driven
        i2c_start();
        write_byte(8'h20, ack);
        regb = 8'h07;
        for (int i = 7; i >= 0; i--) i2c_bit(regb[i], r);
        msda = 1'b1; tick(Q);
        scl  = 1'b1; tick(Q);
        check("x_ack_driven", {31'd0, sda_drv_lo}, 32'd1);
        reset_n = 1'b0; tick(1);
        reset_n = 1'b1;
        check("x_drv_released", {31'd0, sda_drv_lo}, 32'd0);
        check("x_state", {28'd0, dut.state}, 32'd0);
        check("x_addr", {26'd0, bus.addr}, 32'h00);
        tick(1);
        check("x_no_strobe", {30'd0, bus.read, bus.write}, 32'd0);
        tick(Q);
        scl = 1'b0; tick(Q);
        i2c_stop();
        tick(10);
        wb = wr_cnt;
        i2c_start();
        write_byte(8'h20, ack);
        write_byte(8'h02, ack);
        write_byte(8'h99, ack); check("x_w_ack", {31'd0, ack}, 32'd1);
        i2c_stop();
        tick(20);
        check("x_w_cnt", wr_cnt - wb, 32'd1);
        check("x_w_addr", {24'd0, wr_addr_log[wb]}, 32'h02);
        check("x_w_data", {24'd0, wr_data_log[wb]}, 32'h99);
        check("x_final_addr", {26'd0, bus.addr}, 32'h03);

        // Stop after four data bits aborts the byte
        i2c_start();
        write_byte(8'h20, ack);
        write_byte(8'h0A, ack);
        wb = wr_cnt;
        for (int i = 0; i < 4; i++) i2c_bit(i[0], r);
        i2c_stop();
        tick(20);
        check("s_no_write", wr_cnt - wb, 32'd0);
        check("s_state", {28'd0, dut.state}, 32'd0);
        check("s_addr", {26'd0, bus.addr}, 32'h0A);
        check("s_drv", {31'd0, sda_drv_lo}, 32'd0);

        check("never_both", both_cnt, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
